// File: rtl/write_arbiter_pkg.sv
// Shared types and helpers for the write arbiter and its round-robin picker.
package write_arbiter_pkg;

    // Arbiter control states: nothing held, word on offer, budget spent.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_picker
    import write_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          any,
    output logic [SW-1:0] idx,
    output logic [N-1:0]  sel
);

    // One extra bit so ptr + k (at most 2N-2) never overflows before the wrap.
    localparam logic [SW:0] NW = (SW+1)'(N);

    logic [SW:0] pos;

    // Walk requesters in the order ptr, ptr+1, ... N-1, 0, ...; first hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        sel = '0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (SW+1)'(k);
            if (pos >= NW) begin
                pos = pos - NW;
            end
            if (!any && req[pos[SW-1:0]]) begin
                any           = 1'b1;
                idx           = pos[SW-1:0];
                sel[pos[SW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/write_arbiter.sv
// Round-robin write arbiter: funnels N requesters onto one valid/ready port
// and stops granting once MAX_GRANTS transfers have completed (0 = no limit).
//
// Handshake: out_valid/out_data/out_src stay stable while out_valid=1 and
// out_ready=0; a transfer completes on a clock edge where both are 1. On the
// requester side, ack[i] is a one-cycle pulse meaning "your word was captured
// on this edge"; the requester then drops req[i] or presents its next word.
module write_arbiter
    import write_arbiter_pkg::*;
#(
    parameter int          N          = 4,
    parameter int          WIDTH      = 32,
    parameter int unsigned MAX_GRANTS = 0,
    localparam int         SW         = idx_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] data,
    output logic [N-1:0]       ack,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_src,
    output logic               done,
    output logic [31:0]        grant_count,
    output arb_state_t         dbg_state
);

    localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);
    localparam logic [31:0]   CNT_MAX  = '1;
    localparam logic [31:0]   BUDGET   = MAX_GRANTS;

    arb_state_t       state;
    arb_state_t       state_next;
    logic [SW-1:0]    ptr;
    logic [SW-1:0]    ptr_after;
    logic [SW-1:0]    pick_ptr;
    logic [SW-1:0]    pick_idx;
    logic [N-1:0]     pick_sel;
    logic             pick_any;
    logic [WIDTH-1:0] pick_word;
    logic             handshake;
    logic             budget_hit;
    logic             capture;
    logic [31:0]      cnt_next;

    assign handshake  = (state == HOLD) && out_ready;
    assign cnt_next   = (grant_count == CNT_MAX) ? grant_count : grant_count + 32'd1;
    assign budget_hit = (BUDGET != 32'd0) && (cnt_next == BUDGET);
    assign ptr_after  = (out_src == LAST_IDX) ? '0 : out_src + SW'(1);
    // In HOLD the only pick that matters is the back-to-back one after a
    // completed transfer, which must already see the advanced pointer.
    assign pick_ptr   = (state == HOLD) ? ptr_after : ptr;

    rr_picker #(
        .N  (N),
        .SW (SW)
    ) u_picker (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx),
        .sel (pick_sel)
    );

    // Select the picked requester's word using the one-hot grant.
    always_comb begin
        pick_word = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_sel[i]) begin
                pick_word = data[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and capture decision.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_next = HOLD;
                    capture    = 1'b1;
                end
            end
            HOLD: begin
                if (handshake) begin
                    if (budget_hit) begin
                        state_next = DONE;
                    end else if (pick_any) begin
                        state_next = HOLD;
                        capture    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State-derived outputs.
    always_comb begin
        out_valid = (state == HOLD);
        done      = (state == DONE);
        dbg_state = state;
    end

    // Captured word, ack pulse, pointer and transfer counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data    <= '0;
            out_src     <= '0;
            ack         <= '0;
            ptr         <= '0;
            grant_count <= '0;
        end else begin
            ack <= capture ? pick_sel : '0;
            if (capture) begin
                out_data <= pick_word;
                out_src  <= pick_idx;
            end
            if (handshake) begin
                grant_count <= cnt_next;
                ptr         <= ptr_after;
            end
        end
    end

endmodule

// File: tb/tb_write_arbiter.sv
// Bench for write_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
module tb_write_arbiter;
    import write_arbiter_pkg::*;

    localparam int NA = 4;
    localparam int W  = 32;

    logic clk;
    logic rst;

    // DUT A: N=4, unlimited budget (model-checked every cycle)
    logic [NA-1:0]   a_req;
    logic [W-1:0]    a_word [NA];
    logic [NA*W-1:0] a_data;
    logic [NA-1:0]   a_ack;
    logic            a_out_valid;
    logic            a_ready;
    logic [W-1:0]    a_out_data;
    logic [1:0]      a_out_src;
    logic            a_done;
    logic [31:0]     a_grant_count;
    arb_state_t      a_dbg_state;

    // DUT B: N=4, budget of 4
    logic [NA-1:0]   b_req;
    logic [W-1:0]    b_word [NA];
    logic [NA*W-1:0] b_data;
    logic [NA-1:0]   b_ack;
    logic            b_out_valid;
    logic            b_ready;
    logic [W-1:0]    b_out_data;
    logic [1:0]      b_out_src;
    logic            b_done;
    logic [31:0]     b_grant_count;
    arb_state_t      b_dbg_state;

    // DUT C: N=1, budget of 1
    logic [0:0]      c_req;
    logic [W-1:0]    c_data;
    logic [0:0]      c_ack;
    logic            c_out_valid;
    logic            c_ready;
    logic [W-1:0]    c_out_data;
    logic [0:0]      c_out_src;
    logic            c_done;
    logic [31:0]     c_grant_count;
    arb_state_t      c_dbg_state;

    assign a_data = {a_word[3], a_word[2], a_word[1], a_word[0]};
    assign b_data = {b_word[3], b_word[2], b_word[1], b_word[0]};

    write_arbiter #(.N(NA), .WIDTH(W), .MAX_GRANTS(0)) dut_a (
        .clk(clk), .rst(rst), .req(a_req), .data(a_data), .ack(a_ack),
        .out_valid(a_out_valid), .out_ready(a_ready), .out_data(a_out_data),
        .out_src(a_out_src), .done(a_done), .grant_count(a_grant_count),
        .dbg_state(a_dbg_state)
    );

    write_arbiter #(.N(NA), .WIDTH(W), .MAX_GRANTS(4)) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .data(b_data), .ack(b_ack),
        .out_valid(b_out_valid), .out_ready(b_ready), .out_data(b_out_data),
        .out_src(b_out_src), .done(b_done), .grant_count(b_grant_count),
        .dbg_state(b_dbg_state)
    );

    write_arbiter #(.N(1), .WIDTH(W), .MAX_GRANTS(1)) dut_c (
        .clk(clk), .rst(rst), .req(c_req), .data(c_data), .ack(c_ack),
        .out_valid(c_out_valid), .out_ready(c_ready), .out_data(c_out_data),
        .out_src(c_out_src), .done(c_done), .grant_count(c_grant_count),
        .dbg_state(c_dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    bit drop_en  = 1'b0;
    bit raise_en = 1'b0;

    // Scoreboard: words the model says completed vs words seen handshaking.
    logic [W-1:0] exp_q [$];
    logic [W-1:0] got_q [$];

    // Transaction-level model of DUT A
    bit          m_hold;
    bit          m_done;
    logic [W-1:0] m_word;
    int          m_src;
    int          m_ptr;
    logic [31:0] m_cnt;
    logic [NA-1:0] m_ack;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 1'b0;
        m_done = 1'b0;
        m_word = '0;
        m_src  = 0;
        m_ptr  = 0;
        m_cnt  = '0;
        m_ack  = '0;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        bit want_pick;
        bit found;
        int j;
        m_ack     = '0;
        want_pick = 1'b0;
        if (m_done) begin
            want_pick = 1'b0;
        end else if (m_hold) begin
            if (a_ready) begin
                exp_q.push_back(m_word);
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                m_ptr  = (m_src + 1) % NA;
                m_hold = 1'b0;
                want_pick = 1'b1;
            end
        end else begin
            want_pick = 1'b1;
        end
        if (want_pick) begin
            found = 1'b0;
            for (int k = 0; k < NA; k++) begin
                j = (m_ptr + k) % NA;
                if (!found && a_req[j]) begin
                    found    = 1'b1;
                    m_hold   = 1'b1;
                    m_src    = j;
                    m_word   = a_word[j];
                    m_ack[j] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_a();
        arb_state_t e;
        e = m_done ? DONE : (m_hold ? HOLD : IDLE);
        check("a_valid", a_out_valid, m_hold);
        check("a_ack",   a_ack, m_ack);
        check("a_count", a_grant_count, m_cnt);
        check("a_done",  a_done, m_done);
        check("a_state", a_dbg_state, e);
        if (m_hold) begin
            check("a_src",  a_out_src, m_src);
            check("a_data", a_out_data, m_word);
        end
    endtask

    // Requesters: on ack, present the next counter value and maybe drop out.
    task automatic service();
        for (int i = 0; i < NA; i++) begin
            if (a_ack[i]) begin
                a_word[i] = a_word[i] + 1;
                if (drop_en && ($urandom_range(0, 2) == 0)) a_req[i] = 1'b0;
            end else if (raise_en && !a_req[i] && ($urandom_range(0, 1) == 1)) begin
                a_req[i] = 1'b1;
            end
            if (b_ack[i]) b_word[i] = b_word[i] + 1;
        end
    endtask

    // One clock: log handshake, step model, cross the edge, compare, respond.
    task automatic tick();
        if (!rst && a_out_valid && a_ready) got_q.push_back(a_out_data);
        if (!rst) model_step();
        @(posedge clk);
        #1;
        if (!rst) compare_a();
        service();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    logic [W-1:0] held;
    logic [W-1:0] b_vals [$];
    bit           b_hs;
    logic [W-1:0] b_w;

    initial begin
        rst = 1'b1;
        a_req = '0; a_ready = 1'b0;
        b_req = '0; b_ready = 1'b0;
        c_req = '0; c_ready = 1'b0; c_data = '0;
        for (int i = 0; i < NA; i++) begin
            a_word[i] = W'(i) << 16;
            b_word[i] = '0;
        end
        do_reset();

        // Reset values
        check("rst_valid", a_out_valid, 0);
        check("rst_data",  a_out_data, 0);
        check("rst_src",   a_out_src, 0);
        check("rst_ack",   a_ack, 0);
        check("rst_done",  a_done, 0);
        check("rst_count", a_grant_count, 0);

        // Single requester 2 held, sink always ready
        a_word[2] = 32'h0002_0000;
        a_req     = 4'b0100;
        a_ready   = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("single_src",   a_out_src, 2);
            check("single_ack",   a_ack, 4'b0100);
            check("single_count", a_grant_count, k - 1);
            check("single_data",  a_out_data, 32'h0002_0000 + k - 1);
        end
        a_req = '0;
        tick();
        check("single_idle",  a_out_valid, 0);
        check("single_final", a_grant_count, 4);

        // All four requesting from reset: strict rotation
        do_reset();
        a_req   = 4'hF;
        a_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_src", a_out_src, k % 4);
            check("rr_ack", a_ack, 4'b0001 << (k % 4));
        end

        // Backpressure: held word stays put, nothing acked or counted
        a_ready = 1'b0;
        held    = a_out_data;
        check("bp_start_count", a_grant_count, 5);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", a_out_valid, 1);
            check("bp_data",  a_out_data, held);
            check("bp_ack",   a_ack, 0);
            check("bp_count", a_grant_count, 5);
        end
        a_ready = 1'b1;
        tick();
        check("bp_release_count", a_grant_count, 6);
        check("bp_release_src",   a_out_src, 2);

        // Reset in the middle of HOLD with word 7 on offer
        do_reset();
        a_req   = 4'b0010;
        a_ready = 1'b1;
        tick();
        a_req     = 4'b0001;
        a_word[0] = 32'h7;
        tick();
        check("mid_src",  a_out_src, 0);
        check("mid_data", a_out_data, 32'h7);
        a_ready = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_valid", a_out_valid, 0);
        check("mid_rst_data",  a_out_data, 0);
        check("mid_rst_src",   a_out_src, 0);
        check("mid_rst_ack",   a_ack, 0);
        check("mid_rst_count", a_grant_count, 0);
        @(posedge clk); #1;
        rst     = 1'b0;
        a_req   = 4'hF;
        a_ready = 1'b1;
        tick();
        check("after_rst_src", a_out_src, 0);
        check("after_rst_ack", a_ack, 4'b0001);

        // Randomized traffic against the model
        drop_en  = 1'b1;
        raise_en = 1'b1;
        a_req    = 4'($urandom_range(0, 15));
        for (int n = 0; n < 400; n++) begin
            a_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drop_en  = 1'b0;
        raise_en = 1'b0;

        // Budget of 4 with a counting requester
        b_word[1] = 32'd0;
        b_req     = 4'b0010;
        b_ready   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            b_hs = b_out_valid && b_ready;
            b_w  = b_out_data;
            tick();
            if (b_hs) b_vals.push_back(b_w);
            check("b_done", b_done, (b_vals.size() >= 4));
            if (b_vals.size() >= 4) begin
                check("b_no_ack",   b_ack, 0);
                check("b_no_valid", b_out_valid, 0);
            end
        end
        check("b_transfers", b_vals.size(), 4);
        for (int i = 0; i < b_vals.size() && i < 4; i++) begin
            check("b_value", b_vals[i], i);
        end
        check("b_count", b_grant_count, 4);

        // Single requester, budget of 1
        c_data  = 32'hA5;
        c_req   = 1'b1;
        c_ready = 1'b1;
        tick();
        check("c_valid", c_out_valid, 1);
        check("c_ack",   c_ack, 1);
        check("c_src",   c_out_src, 0);
        check("c_data",  c_out_data, 32'hA5);
        tick();
        check("c_done",      c_done, 1);
        check("c_count",     c_grant_count, 1);
        check("c_valid_end", c_out_valid, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("c_no_ack",  c_ack, 0);
            check("c_count_h", c_grant_count, 1);
        end

        // Every completed transfer seen at the port, in order
        check("sb_len", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check("sb_word", got_q[i], exp_q[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
